mover_scheduler: RTL and testbench

- Upstream sequencer for the data mover.
- Queues host destination addresses, waits until the source buffer holds a full frame, then issues a one-cycle start with a stable destination address.
- Detects move completion by counting write responses on the destination AXI B-channel, which it observes passively.
- Reports each completed move, with status, on a ready/valid completion channel.

---
 rtl/mover_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_mover_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mover_scheduler.sv
// mover_scheduler: queues destination addresses, starts the data mover once a full
// frame is buffered, counts DST B-channel handshakes to detect completion and reports
// each finished move on a ready/valid completion channel.
// Optional watchdog: define MOVER_SCHEDULER_WATCHDOG_EN to abort a stalled move after
// TIMEOUT_CYCLES idle cycles in WAIT_B (reported with status 2).
module mover_scheduler #(
  parameter int unsigned BYTE_COUNT     = 1048576,
  parameter int unsigned BURST_SIZE     = 2048,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [63:0]                   addr_tdata,
  input  logic                          addr_tvalid,
  output logic                          addr_tready,
  input  logic                          frame_avail,
  output logic                          mover_start,
  output logic [63:0]                   mover_dest,
  input  logic                          dst_bvalid,
  input  logic                          dst_bready,
  input  logic [1:0]                    dst_bresp,
  output logic [63:0]                   done_tdata,
  output logic [1:0]                    done_tuser,
  output logic                          done_tvalid,
  input  logic                          done_tready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] Bursts = 32'(BYTE_COUNT / BURST_SIZE);

  typedef enum logic [1:0] {StIdle, StStart, StWaitB, StReport} state_e;

  state_e        state_q, state_d;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q;
  logic [63:0]   dest_q, dest_d;
  logic [31:0]   bcnt_q, bcnt_d;
  logic          err_q, err_d;
  logic          full, accept, push, pop, b_hs;
  logic          wd_expire, timeout;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  // ready_q keeps addr_tready low during reset and for the first cycle after it
  assign addr_tready = ready_q & ~full;
  assign accept      = addr_tvalid & addr_tready;
  // A zero destination is consumed but never queued; the mover would ignore it
  assign push        = accept & (addr_tdata != 64'd0);
  assign pop         = (state_q == StIdle) & (count_q != '0) & frame_avail;
  assign b_hs        = dst_bvalid & dst_bready;

  // Queue occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Queue storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= addr_tdata;
    end
  end

  // Queue pointers, occupancy and input-ready flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

`ifdef MOVER_SCHEDULER_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic        to_q, to_d;

  // Expiry lands on the edge TIMEOUT_CYCLES cycles after the last handshake/start
  assign wd_expire = (state_q == StWaitB) & ~b_hs & (wd_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout   = to_q;

  // Watchdog next-state: counts idle WAIT_B cycles, flags the expiry for REPORT
  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (state_q == StStart) begin
      wd_d = '0;
      to_d = 1'b0;
    end else if (state_q == StWaitB) begin
      wd_d = b_hs ? 32'd0 : wd_q + 32'd1;
      if (wd_expire) to_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
  assign timeout        = 1'b0;
`endif

  // Sequencer next-state: pop/start, count B responses, hold the report until taken
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          dest_d  = mem_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        bcnt_d  = '0;
        err_d   = 1'b0;
        state_d = StWaitB;
      end
      StWaitB: begin
        if (wd_expire) begin
          state_d = StReport;
        end else if (b_hs) begin
          bcnt_d = bcnt_q + 32'd1;
          if (dst_bresp != 2'b00) err_d = 1'b1;
          if (bcnt_q + 32'd1 == Bursts) state_d = StReport;
        end
      end
      StReport: begin
        if (done_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      dest_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  assign mover_start = (state_q == StStart);
  assign mover_dest  = dest_q;
  assign busy        = (state_q != StIdle);
  assign done_tvalid = (state_q == StReport);
  assign done_tdata  = done_tvalid ? dest_q : 64'd0;
  assign done_tuser  = !done_tvalid ? 2'd0 : (timeout ? 2'd2 : {1'b0, err_q});
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_mover_scheduler.sv
// Directed self-checking bench for mover_scheduler (4 bursts per move, 8-deep queue).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mover_scheduler;

  localparam int unsigned Bursts = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] addr_tdata = '0;
  logic        addr_tvalid = 1'b0;
  logic        addr_tready;
  logic        frame_avail = 1'b0;
  logic        mover_start;
  logic [63:0] mover_dest;
  logic        dst_bvalid = 1'b0;
  logic        dst_bready = 1'b0;
  logic [1:0]  dst_bresp = 2'd0;
  logic [63:0] done_tdata;
  logic [1:0]  done_tuser;
  logic        done_tvalid;
  logic        done_tready = 1'b0;
  logic        busy;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  int n_done_cyc = 0;

  mover_scheduler #(
    .BYTE_COUNT    (8192),
    .BURST_SIZE    (2048),
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .addr_tdata (addr_tdata),
    .addr_tvalid(addr_tvalid),
    .addr_tready(addr_tready),
    .frame_avail(frame_avail),
    .mover_start(mover_start),
    .mover_dest (mover_dest),
    .dst_bvalid (dst_bvalid),
    .dst_bready (dst_bready),
    .dst_bresp  (dst_bresp),
    .done_tdata (done_tdata),
    .done_tuser (done_tuser),
    .done_tvalid(done_tvalid),
    .done_tready(done_tready),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Event counters sampled at the rising edge, before registers update
  always @(posedge clk) begin
    if (mover_start === 1'b1) n_starts++;
    if (done_tvalid === 1'b1) n_done_cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, 64'(addr_tready), 64'd0);
    check({tag, "_start"}, 64'(mover_start), 64'd0);
    check({tag, "_dest"}, mover_dest, 64'd0);
    check({tag, "_tdata"}, done_tdata, 64'd0);
    check({tag, "_tuser"}, 64'(done_tuser), 64'd0);
    check({tag, "_tvalid"}, 64'(done_tvalid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_count"}, 64'(fifo_count), 64'd0);
  endtask

  task automatic push(input logic [63:0] a);
    check("push_ready", 64'(addr_tready), 64'd1);
    addr_tvalid = 1'b1;
    addr_tdata  = a;
    @(negedge clk);
    addr_tvalid = 1'b0;
    addr_tdata  = '0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (mover_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 64'(mover_start), 64'd1);
  endtask

  task automatic b_hs(input int n, input int err_idx);
    for (int i = 0; i < n; i++) begin
      dst_bvalid = 1'b1;
      dst_bready = 1'b1;
      dst_bresp  = (i == err_idx) ? 2'd2 : 2'd0;
      @(negedge clk);
    end
    dst_bvalid = 1'b0;
    dst_bready = 1'b0;
    dst_bresp  = 2'd0;
  endtask

  // One full move: start, a non-handshake B cycle, Bursts handshakes, report, accept
  task automatic do_move(input logic [63:0] a, input int err_idx, input logic [1:0] user);
    wait_start();
    check("dest", mover_dest, a);
    @(negedge clk);
    check("start_one_cycle", 64'(mover_start), 64'd0);
    dst_bvalid = 1'b1;
    dst_bready = 1'b0;
    dst_bresp  = 2'd2;
    @(negedge clk);
    for (int i = 0; i < int'(Bursts); i++) begin
      check("done_early", 64'(done_tvalid), 64'd0);
      dst_bvalid = 1'b1;
      dst_bready = 1'b1;
      dst_bresp  = (i == err_idx) ? 2'd2 : 2'd0;
      @(negedge clk);
    end
    dst_bvalid = 1'b0;
    dst_bready = 1'b0;
    dst_bresp  = 2'd0;
    check("done_valid", 64'(done_tvalid), 64'd1);
    check("done_tdata", done_tdata, a);
    check("done_tuser", 64'(done_tuser), 64'(user));
    check("dest_hold", mover_dest, a);
    done_tready = 1'b1;
    @(negedge clk);
    done_tready = 1'b0;
    check("idle_after_done", 64'(busy), 64'd0);
    check("done_dropped", 64'(done_tvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0;
    int d0;
    int k;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    resetn = 1'b1;
    #1;
    check("tready_after_deassert", 64'(addr_tready), 64'd0);
    @(negedge clk);
    check("tready_rises", 64'(addr_tready), 64'd1);

    // Single OKAY move with exact start latency
    frame_avail = 1'b1;
    push(64'h1_0000_0000);
    check("count_after_push", 64'(fifo_count), 64'd1);
    check("no_start_yet", 64'(mover_start), 64'd0);
    @(negedge clk);
    check("start_latency", 64'(mover_start), 64'd1);
    check("count_after_pop", 64'(fifo_count), 64'd0);
    do_move(64'h1_0000_0000, -1, 2'd0);
    check("one_start", 64'(n_starts), 64'd1);

    // Error flag, then cleared on the next move
    push(64'h2000);
    do_move(64'h2000, 1, 2'd1);
    push(64'h3000);
    do_move(64'h3000, -1, 2'd0);

    // Full queue and zero address
    frame_avail = 1'b0;
    for (int i = 0; i < 7; i++) push(64'h100 * 64'(i + 1));
    check("count7", 64'(fifo_count), 64'd7);
    push(64'd0);
    check("zero_discarded", 64'(fifo_count), 64'd7);
    push(64'h800);
    check("count8", 64'(fifo_count), 64'd8);
    check("full_not_ready", 64'(addr_tready), 64'd0);
    addr_tvalid = 1'b1;
    addr_tdata  = 64'h900;
    @(negedge clk);
    addr_tvalid = 1'b0;
    check("ninth_rejected", 64'(fifo_count), 64'd8);
    check("still_idle", 64'(busy), 64'd0);

    // Backpressure on the report with stray B handshakes
    frame_avail = 1'b1;
    wait_start();
    check("bp_dest", mover_dest, 64'h100);
    check("bp_count", 64'(fifo_count), 64'd7);
    @(negedge clk);
    b_hs(Bursts, -1);
    s0 = n_starts;
    for (int c = 0; c < 20; c++) begin
      if (c == 3 || c == 8 || c == 13) begin
        dst_bvalid = 1'b1;
        dst_bready = 1'b1;
        dst_bresp  = 2'd2;
      end else begin
        dst_bvalid = 1'b0;
        dst_bready = 1'b0;
        dst_bresp  = 2'd0;
      end
      @(negedge clk);
      check("bp_valid", 64'(done_tvalid), 64'd1);
      check("bp_tdata", done_tdata, 64'h100);
      check("bp_tuser", 64'(done_tuser), 64'd0);
    end
    dst_bvalid = 1'b0;
    dst_bready = 1'b0;
    dst_bresp  = 2'd0;
    check("bp_no_start", 64'(n_starts), 64'(s0));
    done_tready = 1'b1;
    @(negedge clk);
    done_tready = 1'b0;
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_gap_start", 64'(mover_start), 64'd0);
    @(negedge clk);
    check("bp_next_start", 64'(mover_start), 64'd1);
    check("bp_next_dest", mover_dest, 64'h200);

    // Clean reset before the gating test
    resetn = 1'b0;
    frame_avail = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst2_count", 64'(fifo_count), 64'd0);

    // frame_avail gating
    push(64'h10);
    push(64'h20);
    s0 = n_starts;
    repeat (10) @(negedge clk);
    check("gate_no_start", 64'(n_starts), 64'(s0));
    check("gate_count", 64'(fifo_count), 64'd2);
    check("gate_idle", 64'(busy), 64'd0);
    frame_avail = 1'b1;
    do_move(64'h10, -1, 2'd0);

    // Reset in the middle of WAIT_B
    wait_start();
    check("mid_dest", mover_dest, 64'h20);
    @(negedge clk);
    b_hs(2, -1);
    push(64'h30);
    check("mid_count", 64'(fifo_count), 64'd1);
    check("mid_busy", 64'(busy), 64'd1);
    d0 = n_done_cyc;
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", 64'(n_done_cyc), 64'(d0));
    check("midrst_idle", 64'(busy), 64'd0);
    check("midrst_ready", 64'(addr_tready), 64'd1);

    // Stalled move: watchdog expiry or indefinite wait
    push(64'h40);
    wait_start();
    @(negedge clk);
    b_hs(2, -1);
    k = 0;
    while (done_tvalid !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
`ifdef MOVER_SCHEDULER_WATCHDOG_EN
    check("wd_cycles", 64'(k), 64'd100);
    check("wd_tuser", 64'(done_tuser), 64'd2);
    check("wd_tdata", done_tdata, 64'h40);
    b_hs(1, -1);
    check("wd_stray_tuser", 64'(done_tuser), 64'd2);
    done_tready = 1'b1;
    @(negedge clk);
    done_tready = 1'b0;
    check("wd_idle", 64'(busy), 64'd0);
`else
    check("nowd_waiting", 64'(done_tvalid), 64'd0);
    check("nowd_busy", 64'(busy), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
